// File: rtl/axil_intc_pkg.sv
// Shared register map, response codes and FSM encodings for the AXI4-Lite interrupt controller.
package axil_intc_pkg;

    // Byte offsets; decoding uses bits [4:2] only.
    localparam logic [4:0] ISR  = 5'h00;
    localparam logic [4:0] IPR  = 5'h04;
    localparam logic [4:0] IER  = 5'h08;
    localparam logic [4:0] IAR  = 5'h0C;
    localparam logic [4:0] SIE  = 5'h10;
    localparam logic [4:0] CIE  = 5'h14;
    localparam logic [4:0] RSVD = 5'h18;
    localparam logic [4:0] MER  = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int MER_ME  = 0;
    localparam int MER_HIE = 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axil_intc_regif.sv
// AXI4-Lite slave front end: write and read FSMs turning bus transactions into a simple
// register write strobe and a combinational read port.
module axil_intc_regif
    import axil_intc_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic              rd_err
);

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    // Holds every ready low while reset is asserted and until the first clock after release.
    logic        live_q, live_d;

    assign wr_addr  = s_awaddr;
    assign wr_data  = s_wdata;
    assign rd_addr  = s_araddr;
    assign s_bresp  = bresp_q;
    assign s_bvalid = (w_state_q == W_RESP);
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_rvalid = (r_state_q == R_DATA);
    assign live_d   = 1'b1;

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (live_q && s_awvalid && s_wvalid) begin
                    s_awready = 1'b1;
                    s_wready  = 1'b1;
                    wr_en     = 1'b1;
                    bresp_d   = (s_awaddr[4:2] == RSVD[4:2]) ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_state_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        s_arready = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_arready = live_q;
                if (live_q && s_arvalid) begin
                    rdata_d   = rd_err ? 32'd0 : rd_data;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
            live_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            live_q    <= live_d;
        end
    end

endmodule

// File: rtl/axil_intc_ctrl.sv
// Interrupt controller core: pending/enable/master-enable registers, edge/level source
// capture and the registered irq to the PS, behind the AXI4-Lite register interface.
module axil_intc_ctrl
    import axil_intc_pkg::*;
#(
    parameter int          NUM_INTR  = 8,
    parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF,
    parameter int          ADDR_W    = 5
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [NUM_INTR-1:0] intr_in,
    output logic                irq,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [31:0]         S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam logic [NUM_INTR-1:0] EDGE_M = EDGE_MASK[NUM_INTR-1:0];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         wr_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic [31:0]         rd_data;
    logic                rd_err;
    logic [NUM_INTR-1:0] isr_q, isr_d;
    logic [NUM_INTR-1:0] ier_q, ier_d;
    logic [NUM_INTR-1:0] intr_prev_q, intr_prev_d;
    logic [NUM_INTR-1:0] hw_set;
    logic [NUM_INTR-1:0] wdat;
    logic                me_q, me_d;
    logic                hie_q, hie_d;
    logic                irq_q, irq_d;
    logic                unused_bits;

    // WSTRB, sub-word address bits and data bits above NUM_INTR carry no meaning here.
    assign unused_bits = ^{S_AXI_WSTRB, wr_data, wr_addr, rd_addr};
    assign irq         = irq_q;

    axil_intc_regif #(.ADDR_W(ADDR_W)) u_regif (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .s_awaddr  (S_AXI_AWADDR),
        .s_awvalid (S_AXI_AWVALID),
        .s_awready (S_AXI_AWREADY),
        .s_wdata   (S_AXI_WDATA),
        .s_wvalid  (S_AXI_WVALID),
        .s_wready  (S_AXI_WREADY),
        .s_bresp   (S_AXI_BRESP),
        .s_bvalid  (S_AXI_BVALID),
        .s_bready  (S_AXI_BREADY),
        .s_araddr  (S_AXI_ARADDR),
        .s_arvalid (S_AXI_ARVALID),
        .s_arready (S_AXI_ARREADY),
        .s_rdata   (S_AXI_RDATA),
        .s_rresp   (S_AXI_RRESP),
        .s_rvalid  (S_AXI_RVALID),
        .s_rready  (S_AXI_RREADY),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_err    (rd_err)
    );

    always_comb begin
        hw_set      = (intr_in & ~intr_prev_q & EDGE_M) | (intr_in & ~EDGE_M);
        wdat        = wr_data[NUM_INTR-1:0];
        intr_prev_d = intr_in;
        isr_d       = isr_q;
        ier_d       = ier_q;
        me_d        = me_q;
        hie_d       = hie_q;
        if (wr_en) begin
            case (wr_addr[4:2])
                ISR[4:2]: if (!hie_q) isr_d = isr_q | wdat;
                IAR[4:2]: isr_d = isr_q & ~wdat;
                IER[4:2]: ier_d = wdat;
                SIE[4:2]: ier_d = ier_q | wdat;
                CIE[4:2]: ier_d = ier_q & ~wdat;
                MER[4:2]: begin
                    me_d  = wr_data[MER_ME];
                    hie_d = hie_q | wr_data[MER_HIE];
                end
                default: ;
            endcase
        end
        // Applied after the acknowledge so a same-cycle source event keeps the bit pending.
        isr_d = isr_d | hw_set;
        irq_d = me_q & (|(isr_q & ier_q));
    end

    always_comb begin
        rd_data = 32'd0;
        rd_err  = 1'b0;
        case (rd_addr[4:2])
            ISR[4:2]:  rd_data = 32'(isr_q);
            IPR[4:2]:  rd_data = 32'(isr_q & ier_q);
            IER[4:2]:  rd_data = 32'(ier_q);
            MER[4:2]:  rd_data = {30'd0, hie_q, me_q};
            RSVD[4:2]: rd_err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            isr_q       <= '0;
            ier_q       <= '0;
            intr_prev_q <= '0;
            me_q        <= 1'b0;
            hie_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            ier_q       <= ier_d;
            intr_prev_q <= intr_prev_d;
            me_q        <= me_d;
            hie_q       <= hie_d;
            irq_q       <= irq_d;
        end
    end

endmodule
